// File: rtl/frame_reader_if.sv
// frame_reader_if: bundles the control, SDRAM read and pixel stream signals of
// frame_reader. The master modport is the reader side; slave is the
// environment (SDRAM slave, pixel consumer, control source).
interface frame_reader_if #(
   parameter int unsigned PIXELBITS = 4
);
   // control
   logic                 start;
   logic [31:0]          offset;
   logic [PIXELBITS-1:0] pixel_size;
   logic                 busy;
   logic                 done;
   // SDRAM read port
   logic [31:0]          rd_addr;
   logic                 rd_req;
   logic                 rd_wait;
   logic [31:0]          rd_data;
   logic                 rd_valid;
   // pixel stream
   logic [31:0]          px_data;
   logic [9:0]           px_x;
   logic [9:0]           px_y;
   logic                 px_valid;
   logic                 px_ready;

   modport master (
      input  start, offset, pixel_size, rd_wait, rd_data, rd_valid, px_ready,
      output busy, done, rd_addr, rd_req, px_data, px_x, px_y, px_valid
   );

   modport slave (
      output start, offset, pixel_size, rd_wait, rd_data, rd_valid, px_ready,
      input  busy, done, rd_addr, rd_req, px_data, px_x, px_y, px_valid
   );
endinterface

// File: rtl/frame_reader.sv
// frame_reader: walks a frame in raster order, issues one SDRAM read per
// pixel, buffers the returned words in a small FIFO and presents them with
// their (x, y) coordinates on a ready/valid pixel stream.
// Credit rule: reads in flight plus buffered words never exceed FIFO_DEPTH,
// so the FIFO cannot overflow.
// Optional feature macro: FRAME_READER_WRAP_EN (continuous frame refresh).
module frame_reader #(
   parameter int unsigned PIXELBITS  = 4,
   parameter int unsigned MAX_X      = 640,
   parameter int unsigned MAX_Y      = 480,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   frame_reader_if.master bus
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     offset_q, offset_d;
   logic [31:0]     step_q, step_d;
   logic [31:0]     addr_q, addr_d;
   logic [9:0]      rx_q, rx_d;
   logic [9:0]      ry_q, ry_d;
   logic [9:0]      ox_q, ox_d;
   logic [9:0]      oy_q, oy_d;
   logic            done_q, done_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [31:0]     mem_q [FIFO_DEPTH];

   logic [PIXELBITS-1:0] psize;
   logic            credit_ok;
   logic            req;
   logic            accept;
   logic            push;
   logic            pop;
   logic            fifo_nonempty;
   logic            last_req;
   logic            last_px;

   assign psize         = bus.pixel_size;
   assign fifo_nonempty = (count_q != '0);
   assign credit_ok     = ((inflight_q + count_q) < CW'(FIFO_DEPTH));
   assign req           = (state_q == S_RUN) && credit_ok;
   assign accept        = req && !bus.rd_wait;
   // returns with nothing outstanding are dropped
   assign push          = bus.rd_valid && (inflight_q != '0);
   assign pop           = fifo_nonempty && bus.px_ready;
   assign last_req      = (rx_q == 10'(MAX_X)) && (ry_q == 10'(MAX_Y));
   assign last_px       = (ox_q == 10'(MAX_X)) && (oy_q == 10'(MAX_Y));

   // Next-state logic: frame FSM, request address/coordinates, output coordinates
   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      step_d   = step_q;
      addr_d   = addr_q;
      rx_d     = rx_q;
      ry_d     = ry_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_RUN;
               offset_d = bus.offset;
               step_d   = (psize == '0) ? 32'd1 : 32'(psize);
               addr_d   = bus.offset;
               rx_d     = '0;
               ry_d     = '0;
               ox_d     = '0;
               oy_d     = '0;
            end
         end

         S_RUN, S_DRAIN: begin
            // request side; accept is only possible in RUN
            if (accept) begin
               addr_d = addr_q + step_q;
               if (rx_q == 10'(MAX_X)) begin
                  rx_d = '0;
                  ry_d = ry_q + 10'd1;
               end else begin
                  rx_d = rx_q + 10'd1;
               end
               if (last_req) begin
`ifdef FRAME_READER_WRAP_EN
                  addr_d = offset_q;
                  rx_d   = '0;
                  ry_d   = '0;
`else
                  state_d = S_DRAIN;
`endif
               end
            end

            // output side
            if (pop) begin
               if (ox_q == 10'(MAX_X)) begin
                  ox_d = '0;
                  oy_d = oy_q + 10'd1;
               end else begin
                  ox_d = ox_q + 10'd1;
               end
               if (last_px) begin
                  done_d = 1'b1;
                  ox_d   = '0;
                  oy_d   = '0;
`ifndef FRAME_READER_WRAP_EN
                  state_d = S_IDLE;
`endif
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Next-state logic: in-flight credit counter and FIFO pointers/count
   always_comb begin
      inflight_d = inflight_q;
      count_d    = count_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;

      case ({accept, push})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         offset_q   <= '0;
         step_q     <= 32'd1;
         addr_q     <= '0;
         rx_q       <= '0;
         ry_q       <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         done_q     <= 1'b0;
         inflight_q <= '0;
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         state_q    <= state_d;
         offset_q   <= offset_d;
         step_q     <= step_d;
         addr_q     <= addr_d;
         rx_q       <= rx_d;
         ry_q       <= ry_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         done_q     <= done_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end

   // Return-data storage; contents need no reset since px_data is gated by count
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= bus.rd_data;
   end

   assign bus.rd_addr  = addr_q;
   assign bus.rd_req   = req;
   assign bus.px_valid = fifo_nonempty;
   assign bus.px_data  = fifo_nonempty ? mem_q[rptr_q] : '0;
   assign bus.px_x     = ox_q;
   assign bus.px_y     = oy_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = done_q;

endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: table-driven frame reads against a latency-modelled SDRAM
// responder; expected pixels are queued on each accepted request and
// compared on each pixel transfer. Also exercises mid-frame reset, start
// while busy, a spurious return with nothing outstanding, and (with
// FRAME_READER_WRAP_EN) continuous refresh.
`timescale 1ns/1ps
module tb_frame_reader;

   localparam int PB    = 4;
   localparam int MX    = 3;
   localparam int MY    = 1;
   localparam int DEPTH = 4;
   localparam int NPIX  = (MX + 1) * (MY + 1);
`ifdef FRAME_READER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   frame_reader_if #(.PIXELBITS(PB)) bus ();

   frame_reader #(
      .PIXELBITS (PB),
      .MAX_X     (MX),
      .MAX_Y     (MY),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   typedef struct {
      logic [31:0]   offset;
      logic [PB-1:0] psize;
      bit            wait_rnd;
      int            ready_mode;   // 0 always ready, 1 low for 20 cycles, 2 random
      int            lat;
      int            abort_at;     // reset after this many pixels (0 = never)
      logic [31:0]   last_addr;
   } vec_t;

   typedef struct { logic [31:0] data; int due; } ret_t;
   typedef struct { logic [31:0] data; logic [9:0] x; logic [9:0] y; } pix_t;

   ret_t ret_q[$];
   pix_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   frame_tag = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] t;
      t = 32'(frame_tag);
      return (a * 32'h9E37_79B1) ^ {t[7:0], 24'h0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".rd_req"},   32'(bus.rd_req),   32'd0);
      chk({tag, ".rd_addr"},  bus.rd_addr,       32'd0);
      chk({tag, ".px_valid"}, 32'(bus.px_valid), 32'd0);
      chk({tag, ".px_data"},  bus.px_data,       32'd0);
      chk({tag, ".px_x"},     32'(bus.px_x),     32'd0);
      chk({tag, ".px_y"},     32'(bus.px_y),     32'd0);
      chk({tag, ".busy"},     32'(bus.busy),     32'd0);
      chk({tag, ".done"},     32'(bus.done),     32'd0);
   endtask

   task automatic run_frame(input vec_t v);
      int          cyc, req_n, ret_n, pop_n, frames, idx;
      bit          active, exp_done, need_rst, fin, exp_req;
      bit          stall_prev, hold_prev, acc, xfer, real_rv;
      logic [31:0] stall_addr, hold_data, step, exp_addr;
      pix_t        p;

      step = (v.psize == '0) ? 32'd1 : 32'(v.psize);
      cyc = 0; req_n = 0; ret_n = 0; pop_n = 0; frames = 0;
      active = 0; exp_done = 0; need_rst = 0; fin = 0;
      stall_prev = 0; hold_prev = 0;
      stall_addr = '0; hold_data = '0;
      ret_q.delete();
      exp_q.delete();
      frame_tag++;

      while (!fin) begin
         @(negedge clk);
         if (need_rst) begin
            rst = 1'b1;
            bus.start = 1'b0; bus.rd_valid = 1'b0; bus.px_ready = 1'b0; bus.rd_wait = 1'b0;
            @(posedge clk); #1;
            chk_reset_outputs("abort");
            rst = 1'b0;
            ret_q.delete();
            exp_q.delete();
            fin = 1;
         end else if (cyc > 600) begin
            n_vec++; n_err++;
            $display("FAIL timeout: got %0d pixels expected frame completion", pop_n);
            fin = 1;
         end else begin
            // second start while busy must be ignored
            bus.start      = (cyc == 0) || (cyc == 5);
            bus.offset     = (cyc == 5) ? 32'hDEAD_0000 : v.offset;
            bus.pixel_size = (cyc == 5) ? PB'(7) : v.psize;
            bus.rd_wait    = v.wait_rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            case (v.ready_mode)
               1:       bus.px_ready = (cyc > 20);
               2:       bus.px_ready = ($urandom_range(0, 2) != 0);
               default: bus.px_ready = 1'b1;
            endcase
            real_rv = 0;
            if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
               bus.rd_valid = 1'b1;
               bus.rd_data  = ret_q[0].data;
               void'(ret_q.pop_front());
               real_rv = 1;
            end else begin
               // spurious strobe while nothing is outstanding
               bus.rd_valid = (cyc == 0);
               bus.rd_data  = $urandom;
            end
            #1;
            exp_req = active && (WRAP || req_n < NPIX) && ((req_n - pop_n) < DEPTH);
            chk("rd_req",   32'(bus.rd_req),   32'(exp_req));
            chk("busy",     32'(bus.busy),     32'(active));
            chk("done",     32'(bus.done),     32'(exp_done));
            chk("px_valid", 32'(bus.px_valid), 32'((ret_n - pop_n) > 0));
            if (stall_prev) chk("stall_addr", bus.rd_addr, stall_addr);
            if (hold_prev)  chk("hold_data",  bus.px_data, hold_data);

            acc        = bus.rd_req && !bus.rd_wait;
            xfer       = bus.px_valid && bus.px_ready;
            stall_prev = bus.rd_req && bus.rd_wait;
            stall_addr = bus.rd_addr;
            hold_prev  = bus.px_valid && !bus.px_ready;
            hold_data  = bus.px_data;

            if (acc) begin
               idx      = req_n % NPIX;
               exp_addr = v.offset + step * 32'(idx);
               chk("rd_addr", bus.rd_addr, exp_addr);
               if (idx == NPIX - 1) chk("last_addr", bus.rd_addr, v.last_addr);
               exp_q.push_back('{mem_word(exp_addr), 10'(idx % (MX + 1)), 10'(idx / (MX + 1))});
               ret_q.push_back('{mem_word(bus.rd_addr), cyc + v.lat});
            end
            if (xfer) begin
               if (exp_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL px_extra: got data %h expected no pixel", bus.px_data);
               end else begin
                  p = exp_q.pop_front();
                  chk("px_data", bus.px_data,     p.data);
                  chk("px_x",    32'(bus.px_x),   32'(p.x));
                  chk("px_y",    32'(bus.px_y),   32'(p.y));
               end
            end

            if (exp_done) begin
               fin      = !WRAP;
               need_rst = WRAP && (frames >= 2);
               if (fin) chk("leftover", 32'(exp_q.size() + ret_q.size()), 32'd0);
            end

            @(posedge clk);
            if (cyc == 0) active = 1;
            if (acc) req_n++;
            if (real_rv) ret_n++;
            exp_done = 0;
            if (xfer) begin
               pop_n++;
               if (pop_n % NPIX == 0) begin
                  exp_done = 1;
                  frames++;
                  if (!WRAP) active = 0;
               end
            end
            if (v.abort_at != 0 && pop_n == v.abort_at) need_rst = 1;
            cyc++;
         end
      end
   endtask

   initial begin
      vec_t vecs [7];
      vecs[0] = '{32'h0000_1000, PB'(4),  1'b0, 0, 2, 0, 32'h0000_101C};
      vecs[1] = '{32'h0000_1000, PB'(0),  1'b0, 0, 2, 0, 32'h0000_1007};
      vecs[2] = '{32'h0000_1000, PB'(4),  1'b0, 1, 2, 0, 32'h0000_101C};
      vecs[3] = '{32'h0000_2000, PB'(2),  1'b1, 2, 3, 0, 32'h0000_200E};
      vecs[4] = '{32'hFFFF_FFF8, PB'(4),  1'b0, 0, 1, 0, 32'h0000_0014};
      vecs[5] = '{32'h0000_1000, PB'(4),  1'b0, 0, 2, 3, 32'h0000_101C};
      vecs[6] = '{32'h0000_0040, PB'(15), 1'b1, 0, 3, 0, 32'h0000_00A9};

      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.offset     = '0;
      bus.pixel_size = '0;
      bus.rd_wait    = 1'b0;
      bus.rd_data    = '0;
      bus.rd_valid   = 1'b0;
      bus.px_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run_frame(vecs[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/frame_reader.md
# frame_reader

Streams one rendered frame back out of SDRAM. It walks pixel coordinates (x, y) in raster order and issues one SDRAM word read per pixel at address = (y·(MAX_X+1) + x)·pixel_size + offset. It buffers the returned words and presents each one with its coordinates on a ready/valid pixel stream. It is the read-side counterpart of the worker's pixel address path and feeds the display/readback logic.

## Interface
Parameters:
- PIXELBITS, 4, width of pixel_size
- MAX_X, 640, last column index; row stride is MAX_X+1 pixels
- MAX_Y, 480, last row index
- FIFO_DEPTH, 4, return-data buffer entries (power of 2, ≥2); also the cap on reads in flight plus buffered words

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to read a frame; ignored unless idle
- offset  in  32  frame base address; sampled on accepted start
- pixel_size  in  PIXELBITS  bytes per pixel; sampled on accepted start
- rd_addr  out  32  SDRAM read address
- rd_req  out  1  read request
- rd_wait  in  1  slave stall; request accepted when rd_req && !rd_wait
- rd_data  in  32  read return data
- rd_valid  in  1  return-data strobe, in request order
- px_data  out  32  pixel word
- px_x  out  10  pixel column
- px_y  out  10  pixel row
- px_valid  out  1  pixel output valid
- px_ready  in  1  consumer ready; transfer when px_valid && px_ready
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last pixel is transferred

## Operation
- States:
  - IDLE → RUN on start. Latch offset and pixel_size (0 is latched as 1). Clear request and output coordinates to (0,0). Set rd_addr = offset.
  - RUN: issue requests. On the accepted request for (MAX_X, MAX_Y) → DRAIN.
  - DRAIN: no new requests. When the last pixel transfers → IDLE and pulse done.
- Request side:
  - rd_req is high in RUN only when inflight + fifo_count < FIFO_DEPTH.
  - On acceptance: rd_addr += pixel_size and request x increments. At MAX_X, x wraps to 0 and y increments.
  - rd_addr and rd_req hold stable while rd_wait is high.
- Address arithmetic: 32-bit, wraps modulo 2^32. Because the row stride equals the pixel count per row, the address is a plain running increment and no multiplier is used.
- Return side:
  - On rd_valid, rd_data is pushed to the FIFO and inflight decrements.
  - rd_valid with inflight == 0 is ignored.
  - Accepted request and rd_valid in the same cycle leave inflight unchanged.
- Output side:
  - px_valid = FIFO not empty; px_data = FIFO head.
  - px_x/px_y come from separate output counters, advanced on each transfer with the same wrap rule.
  - Push and pop in the same cycle leave the count unchanged.
  - FIFO overflow is impossible by the credit rule.
- start while busy is ignored.
- Reset values: rd_req 0, rd_addr 0, px_valid 0, px_data 0, px_x 0, px_y 0, busy 0, done 0, FIFO empty, inflight 0, state IDLE.
- Reset mid-frame aborts immediately with no done pulse. The SDRAM interconnect shares rst, so no stale returns arrive afterwards.

## Timing
- rd_req first asserts the cycle after start is sampled.
- A word returned on rd_valid at edge N is presented on px_valid after edge N (one-cycle latency).
- Sustained throughput is one pixel per cycle while rd_wait = 0, read latency < FIFO_DEPTH, and px_ready = 1.
- px_valid and px_data hold while px_ready is low.
- done is high for the single cycle after the final transfer edge; busy drops in that same cycle.
- A start in the done cycle is accepted.

## Configuration
- FRAME_READER_WRAP_EN
  - Defined: continuous refresh. After request (MAX_X, MAX_Y) is accepted, the request side reloads rd_addr = latched offset at (0,0) and stays in RUN. The output counters also wrap to (0,0). done pulses at each frame end while busy stays high. Only rst stops it.
  - Undefined: one frame per start, as described above.

## Test plan
- MAX_X=3, MAX_Y=1, offset=0x1000, pixel_size=4, rd_wait=0, 2-cycle read latency, px_ready=1 -> rd_addr 0x1000,0x1004,…,0x101C. Eight pixels out, last at (3,1). done pulses once. busy is low afterwards.
- Same setup with pixel_size=0 -> addresses 0x1000..0x1007 in steps of 1.
- px_ready held low for 20 cycles -> at most FIFO_DEPTH=4 reads outstanding plus buffered. rd_req is low meanwhile. All 8 pixels are delivered in order after release, with none lost.
- rd_wait toggled randomly -> rd_addr is stable while stalled. Exact address sequence and data order are preserved.
- offset=0xFFFFFFF8, pixel_size=4 -> addresses wrap: 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, …
- rst asserted after 3 pixels -> all outputs return to reset values the next cycle with no done. A new start reads the full frame from (0,0). With FRAME_READER_WRAP_EN defined, the address returns to 0x1000 after 0x101C and done pulses every 8 transfers.
